// File: rtl/level_controller_pkg.sv
// Shared game package: FSM state encoding, per-level speed constants and
// level-up score thresholds, plus small lookup helpers.
package level_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Mole-visible interval in cycles, minus 1, per difficulty level.
    localparam logic [27:0] SPEED_L0 = 28'd99_999_999;
    localparam logic [27:0] SPEED_L1 = 28'd74_999_999;
    localparam logic [27:0] SPEED_L2 = 28'd49_999_999;
    localparam logic [27:0] SPEED_L3 = 28'd24_999_999;

    // Minimum score needed to reach levels 1, 2 and 3.
    localparam logic [7:0] THRESH_L1 = 8'd8;
    localparam logic [7:0] THRESH_L2 = 8'd16;
    localparam logic [7:0] THRESH_L3 = 8'd32;

    function automatic logic [27:0] speed_for_level(input logic [1:0] lvl);
        logic [27:0] s;
        case (lvl)
            2'd0:    s = SPEED_L0;
            2'd1:    s = SPEED_L1;
            2'd2:    s = SPEED_L2;
            default: s = SPEED_L3;
        endcase
        return s;
    endfunction

    // Level 0 has no threshold; it is only ever the starting level.
    function automatic logic [7:0] threshold_for_level(input logic [1:0] lvl);
        logic [7:0] t;
        case (lvl)
            2'd1:    t = THRESH_L1;
            2'd2:    t = THRESH_L2;
            2'd3:    t = THRESH_L3;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/level_controller_second_tick.sv
// One-second prescaler for the level controller.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset
//   enable - count while high; counter is held at 0 while low
//   tick   - one-cycle pulse on the last cycle of every CLK_HZ-cycle period
module second_tick
    import level_controller_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick    = enable && (count_q == LAST);
        count_d = '0;
        if (enable && !tick) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/level_controller.sv
// Game round controller: runs the IDLE/PLAY/OVER game FSM, counts down the
// round in seconds, raises difficulty with score and tracks the best score.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   start        - start button level (rising edge starts a round)
//   stop         - abort request, returns to IDLE
//   score        - current player score
//   game         - high while a round is being played
//   speed        - mole-visible interval (cycles - 1) for the current level
//   level        - difficulty level 0..3
//   time_left    - seconds remaining in the round
//   high_score   - best final score since reset
module level_controller
    import level_controller_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned ROUND_SECONDS = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  score,
    output logic        game,
    output logic [27:0] speed,
    output logic [1:0]  level,
    output logic [6:0]  time_left,
    output logic [7:0]  high_score
);

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        game_q, game_d;
    logic [27:0] speed_q, speed_d;
    logic [1:0]  level_q, level_d;
    logic [6:0]  time_left_q, time_left_d;
    logic [7:0]  high_score_q, high_score_d;

    logic start_edge;
    logic tick_en;
    logic tick;

    // Prescaler runs only while the round continues; a stop cycle clears it
    // so it already reads 0 on arrival in IDLE.
    assign tick_en = (state_q == ST_PLAY) && !stop;

    second_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_second_tick (
        .clock (clock),
        .reset (reset),
        .enable(tick_en),
        .tick  (tick)
    );

    always_comb begin
        start_edge   = start && !start_q;
        start_d      = start;
        state_d      = state_q;
        level_d      = level_q;
        time_left_d  = time_left_q;
        high_score_d = high_score_q;
        // Speed follows the level one cycle late by design.
        speed_d      = speed_for_level(level_q);

        case (state_q)
            ST_PLAY: begin
                if (level_q != 2'd3 && score >= threshold_for_level(level_q + 2'd1)) begin
                    level_d = level_q + 2'd1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (time_left_q == 7'd1) begin
                        state_d     = ST_OVER;
                        time_left_d = '0;
                        if (score > high_score_q) begin
                            high_score_d = score;
                        end
                    end else begin
                        time_left_d = time_left_q - 7'd1;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start_edge) begin
                    state_d     = ST_PLAY;
                    time_left_d = 7'(ROUND_SECONDS);
                    level_d     = '0;
                end
            end
        endcase

        game_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            game_q       <= 1'b0;
            speed_q      <= SPEED_L0;
            level_q      <= '0;
            time_left_q  <= '0;
            high_score_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            game_q       <= game_d;
            speed_q      <= speed_d;
            level_q      <= level_d;
            time_left_q  <= time_left_d;
            high_score_q <= high_score_d;
        end
    end

    assign game       = game_q;
    assign speed      = speed_q;
    assign level      = level_q;
    assign time_left  = time_left_q;
    assign high_score = high_score_q;

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: directed vector table, hand
// sequences for round timeout, stop/start collision, held start and async
// reset, then randomized stimulus against an elapsed-cycle reference model.
module tb_level_controller;

    localparam int CLK_HZ = 10;
    localparam int ROUND  = 3;
    localparam int RC     = CLK_HZ * ROUND;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [7:0]  score = 8'd0;
    logic        game;
    logic [27:0] speed;
    logic [1:0]  level;
    logic [6:0]  time_left;
    logic [7:0]  high_score;

    int checks = 0;
    int errors = 0;

    level_controller #(
        .CLK_HZ(CLK_HZ),
        .ROUND_SECONDS(ROUND)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .score     (score),
        .game      (game),
        .speed     (speed),
        .level     (level),
        .time_left (time_left),
        .high_score(high_score)
    );

    always #5 clock = ~clock;

    // Reference model: round progress is tracked as elapsed cycles in PLAY;
    // seconds left are derived arithmetically from it.
    typedef enum int {M_IDLE, M_PLAY, M_OVER} mstate_t;
    mstate_t m_state;
    int m_elapsed, m_lvl, m_tl, m_hs, m_speed;
    bit m_start_prev;
    int speed_tab[4] = '{99_999_999, 74_999_999, 49_999_999, 24_999_999};
    int thr_tab[4]   = '{0, 8, 16, 32};

    task automatic model_reset();
        m_state = M_IDLE;
        m_elapsed = 0;
        m_lvl = 0;
        m_tl = 0;
        m_hs = 0;
        m_speed = speed_tab[0];
        m_start_prev = 1'b0;
    endtask

    task automatic model_step();
        bit st_edge;
        st_edge = start && !m_start_prev;
        m_speed = speed_tab[m_lvl];
        if (m_state == M_PLAY) begin
            if (m_lvl < 3 && int'(score) >= thr_tab[m_lvl + 1]) m_lvl++;
            if (stop) begin
                m_state = M_IDLE;
            end else begin
                m_elapsed++;
                m_tl = ROUND - m_elapsed / CLK_HZ;
                if (m_elapsed == RC) begin
                    m_state = M_OVER;
                    if (int'(score) > m_hs) m_hs = int'(score);
                end
            end
        end else if (stop) begin
            m_state = M_IDLE;
        end else if (st_edge) begin
            m_state = M_PLAY;
            m_elapsed = 0;
            m_lvl = 0;
            m_tl = ROUND;
        end
        m_start_prev = start;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " game"},       32'(game),       32'(m_state == M_PLAY));
        chk({tag, " level"},      32'(level),      32'(m_lvl));
        chk({tag, " speed"},      32'(speed),      32'(m_speed));
        chk({tag, " time_left"},  32'(time_left),  32'(m_tl));
        chk({tag, " high_score"}, 32'(high_score), 32'(m_hs));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit st;
        bit sp;
        int sc;
        int g;
        int lv;
        int spd;
        int tl;
    } vec_t;

    vec_t vecs[11];
    int   rises;
    logic prev_game;

    initial begin
        vecs[0]  = '{st: 0, sp: 0, sc: 0,  g: 0, lv: 0, spd: 99_999_999, tl: 0};
        vecs[1]  = '{st: 1, sp: 0, sc: 0,  g: 1, lv: 0, spd: 99_999_999, tl: 3};
        vecs[2]  = '{st: 1, sp: 0, sc: 20, g: 1, lv: 1, spd: 99_999_999, tl: 3};
        vecs[3]  = '{st: 1, sp: 0, sc: 20, g: 1, lv: 2, spd: 74_999_999, tl: 3};
        vecs[4]  = '{st: 0, sp: 0, sc: 20, g: 1, lv: 2, spd: 49_999_999, tl: 3};
        vecs[5]  = '{st: 0, sp: 0, sc: 40, g: 1, lv: 3, spd: 49_999_999, tl: 3};
        vecs[6]  = '{st: 0, sp: 0, sc: 40, g: 1, lv: 3, spd: 24_999_999, tl: 3};
        vecs[7]  = '{st: 0, sp: 0, sc: 0,  g: 1, lv: 3, spd: 24_999_999, tl: 3};
        vecs[8]  = '{st: 0, sp: 1, sc: 0,  g: 0, lv: 3, spd: 24_999_999, tl: 3};
        vecs[9]  = '{st: 1, sp: 0, sc: 0,  g: 1, lv: 0, spd: 24_999_999, tl: 3};
        vecs[10] = '{st: 1, sp: 0, sc: 0,  g: 1, lv: 0, spd: 99_999_999, tl: 3};

        model_reset();
        #1;
        apply_reset();
        chk("reset game",       32'(game),       32'd0);
        chk("reset speed",      32'(speed),      32'd99_999_999);
        chk("reset level",      32'(level),      32'd0);
        chk("reset time_left",  32'(time_left),  32'd0);
        chk("reset high_score", 32'(high_score), 32'd0);

        // Directed vector table: start, level ramp, speed lag, stop, restart.
        for (int i = 0; i < 11; i++) begin
            start = vecs[i].st;
            stop  = vecs[i].sp;
            score = 8'(vecs[i].sc);
            step();
            chk($sformatf("vec%0d game", i),      32'(game),      32'(vecs[i].g));
            chk($sformatf("vec%0d level", i),     32'(level),     32'(vecs[i].lv));
            chk($sformatf("vec%0d speed", i),     32'(speed),     32'(vecs[i].spd));
            chk($sformatf("vec%0d time_left", i), 32'(time_left), 32'(vecs[i].tl));
        end

        // Full round timeout with score 5, then a worse round with score 3.
        apply_reset();
        start = 1'b0; stop = 1'b0; score = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        chk("round last-second game", 32'(game),      32'd1);
        chk("round last-second tl",   32'(time_left), 32'd1);
        step();
        chk("timeout game",       32'(game),       32'd0);
        chk("timeout time_left",  32'(time_left),  32'd0);
        chk("timeout high_score", 32'(high_score), 32'd5);
        step();
        chk("over holds game", 32'(game), 32'd0);
        score = 8'd3;
        start = 1'b1;
        step();
        chk("second round game", 32'(game), 32'd1);
        start = 1'b0;
        repeat (30) step();
        chk("second timeout game",       32'(game),       32'd0);
        chk("second timeout high_score", 32'(high_score), 32'd5);

        // Stop and start edge together in PLAY: stop wins, no score update.
        score = 8'd50;
        start = 1'b1;
        step();
        chk("collide enter game", 32'(game), 32'd1);
        start = 1'b0;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        chk("collide game",       32'(game),       32'd0);
        chk("collide high_score", 32'(high_score), 32'd5);
        chk("collide time_left",  32'(time_left),  32'd3);
        start = 1'b0; stop = 1'b0;
        step();
        chk("collide stays idle", 32'(game), 32'd0);

        // Start held high across a whole round: exactly one entry.
        score = 8'd0;
        start = 1'b1;
        rises = 0;
        prev_game = game;
        for (int c = 0; c < 45; c++) begin
            step();
            if (game && !prev_game) rises++;
            prev_game = game;
            if (c == 19) chk("held start in play", 32'(game), 32'd1);
        end
        chk("held start entries", 32'(rises), 32'd1);
        chk("held start over",    32'(game),  32'd0);
        start = 1'b0;
        step();

        // Asynchronous reset between edges mid-PLAY.
        start = 1'b1;
        score = 8'd20;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre-reset level", 32'(level), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async game",       32'(game),       32'd0);
        chk("async level",      32'(level),      32'd0);
        chk("async speed",      32'(speed),      32'd99_999_999);
        chk("async time_left",  32'(time_left),  32'd0);
        chk("async high_score", 32'(high_score), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check_model("post-reset");

        // Randomized stimulus against the reference model.
        start = 1'b0; stop = 1'b0; score = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
                check_model("rand reset");
            end else begin
                if ($urandom_range(0, 3) == 0) start = ~start;
                stop = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 3) == 0) score = 8'($urandom_range(0, 255));
                else score = 8'($urandom_range(0, 40));
                step();
                check_model("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/level_controller.md
LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per second tick.
REQ-002 Parameter ROUND_SECONDS, default 60, length of one game round in seconds (1..127).
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level from the start button; only its rising edge acts.
REQ-006 stop  input  1  level abort request; sampled every cycle.
REQ-007 score  input  8  current score from the player stage, unsigned.
REQ-008 game  output  1  high only in PLAY; gates the display controller and the player.
REQ-009 speed  output  28  mole-visible interval in cycles, minus 1, fed to the display controller.
REQ-010 level  output  2  current difficulty level, 0..3.
REQ-011 time_left  output  7  seconds remaining in the round.
REQ-012 high_score  output  8  best final score since reset.

Function
REQ-013 The block SHALL implement three states: IDLE, PLAY and OVER.
REQ-014 start_edge SHALL be start high this cycle and low the previous cycle, using one registered copy of start.
REQ-015 Transition IDLE->PLAY and OVER->PLAY SHALL occur on start_edge with stop low.
REQ-016 Entering PLAY SHALL load time_left=ROUND_SECONDS, set level=0 and clear the prescaler, all in the same edge.
REQ-017 In PLAY, the prescaler SHALL count CLK_HZ cycles and emit a one-cycle tick on its last cycle; each tick SHALL decrement time_left by 1.
REQ-018 A tick with time_left==1 SHALL take PLAY->OVER, leave time_left=0 and update high_score in the same edge.
REQ-019 The high_score update SHALL be high_score=max(high_score, score) using the score value sampled on that edge.
REQ-020 stop high in PLAY SHALL take PLAY->IDLE next edge without a high_score update; stop high in OVER SHALL take OVER->IDLE.
REQ-021 stop SHALL have priority over start_edge; a timeout SHALL have priority over start_edge in the same cycle.
REQ-022 In PLAY, level SHALL rise by at most one per cycle when score >= threshold[level+1], with thresholds 8, 16, 32 for levels 1, 2, 3; level SHALL saturate at 3 and never decrease during PLAY.
REQ-023 speed SHALL be registered from the level lookup 99_999_999, 74_999_999, 49_999_999, 24_999_999 and SHALL lag level by one cycle.
REQ-024 game SHALL be registered and equal (state==PLAY).
REQ-025 In IDLE and OVER, level and time_left SHALL hold their last values, and the prescaler SHALL hold at 0.

Reset
REQ-026 Reset SHALL force state=IDLE, game=0, level=0, speed=99_999_999, time_left=0, high_score=0, prescaler=0 and the start history=0.
REQ-027 Reset asserted mid-PLAY SHALL take effect immediately without a clock; high_score SHALL be lost.

Structure
REQ-028 The state encoding, the four speed constants and the three level thresholds SHALL live in the shared game package.
REQ-029 The prescaler SHALL be a sub-module second_tick with inputs clock, reset and enable, an output tick, and parameter CLK_HZ.

Verification
REQ-030 Use CLK_HZ=10 and ROUND_SECONDS=3 in the bench for all scenarios.
REQ-031 Scenario: reset, then pulse start -> game=1 one edge later, time_left=3, level=0, speed=99_999_999.
REQ-032 Scenario: hold score=20 during PLAY -> level reaches 1 then 2 on consecutive cycles; speed reaches 49_999_999 one cycle after level=2.
REQ-033 Scenario: let the round run with score=5 -> after 30 cycles, state=OVER, game=0, time_left=0, high_score=5; a second game ending with score=3 leaves high_score=5.
REQ-034 Scenario: assert stop and start_edge in the same PLAY cycle -> state=IDLE, high_score unchanged.
REQ-035 Scenario: hold start high for 20 cycles in IDLE -> exactly one PLAY entry, with no restart while start stays high.
REQ-036 Scenario: assert reset mid-PLAY between clock edges -> all outputs reach their REQ-026 values before the next clock edge.
